dvs_event_gen: RTL and testbench
================================

Name: dvs_event_gen

Overview:
- Emulates a dynamic vision sensor from a conventional 320x240 grayscale camera stream.
- Each incoming pixel is compared against a per-pixel reference held in an external 1-read/1-write BRAM. The block emits an ON/OFF event code and the updated reference, and writes the new reference back.
- Sits directly upstream of the AXI-stream packer. It drives that block's pixel, reference, address and write-enable inputs.

Parameters:
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- FRAME_PIXELS, H_RES*V_RES (76800), pixels per frame; last address is FRAME_PIXELS-1
- ADDR_W, 17, address width

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clock pclk
- vsync  in  1  camera frame sync; a rising edge marks start of frame
- href  in  1  camera line valid
- pix_valid  in  1  pixel strobe, qualified by href
- pix_data  in  8  grayscale pixel
- threshold  in  8  event threshold, sampled at start of frame
- ref_rd_addr  out  ADDR_W  BRAM read address; data returns 1 cycle later
- ref_rd_data  in  10  BRAM read data
- ref_wr_en  out  1  BRAM write strobe
- ref_wr_addr  out  ADDR_W  BRAM write address
- ref_wr_data  out  10  BRAM write data
- pix_out  out  8  event code {pol[1:0], mag[5:0]}
- ref_out  out  10  updated reference for this pixel
- address  out  ADDR_W  pixel index of pix_out/ref_out
- write_enable  out  1  one-cycle pulse per output pixel
- frame_done  out  1  one-cycle pulse after last pixel of a frame is output
- sync_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (asynchronous, reset=0):
  - All outputs are 0; state is WAIT_VS; pixel counter is 0; prime flag is 1; threshold register is 0.
  - Any in-flight pipeline contents are discarded; no BRAM write after reset asserts.
- States:
  - WAIT_VS: wait for a vsync rising edge (vsync=1 and registered vsync=0). On that edge, latch threshold into thr_r, set pix_cnt=0, and go to FRAME.
  - FRAME: accept a pixel when href & pix_valid. After accepting pixel FRAME_PIXELS-1, go to FLUSH.
  - FLUSH: wait 2 cycles for the pipeline to drain, pulse frame_done on the cycle after the last write_enable, clear prime, then go to WAIT_VS.
  - A vsync rising edge while in FRAME with pix_cnt != 0 means a short frame: set sync_err, drain the pipeline normally, restart at pix_cnt=0 with a newly latched threshold. No frame_done is issued and prime is unchanged.
- Pipeline (2-cycle latency):
  - S0, accept cycle: ref_rd_addr=pix_cnt; register pix_data and pix_cnt; pix_cnt increments.
  - S1: ref_rd_data is valid; compute the result.
  - S2: outputs are registered; write_enable=1 for exactly one cycle.
- Arithmetic (S1):
  - cur={pix_data,2'b00} (10 bits).
  - diff=cur-ref_rd_data as 11-bit signed.
  - t={thr_r,2'b00}.
  - If diff > t: pol=2'b01 (ON). If diff < -t: pol=2'b10 (OFF). Otherwise pol=2'b00.
  - mag=min(|diff|>>2, 63) when pol!=0, else 0.
  - new_ref=cur when pol!=0, else ref_rd_data.
  - The comparison is strict, so |diff|==t gives no event. thr_r=0 with diff=0 gives no event.
- Prime frame (first complete frame after reset):
  - pol forced to 00; new_ref=cur for every pixel.
  - ref_wr_en is asserted for every pixel; write_enable stays 0.
- Outputs, on the same S2 cycle:
  - ref_wr_en=1, ref_wr_addr=address, ref_wr_data=new_ref.
  - ref_wr_en is asserted for every pixel, including unchanged ones.
  - pix_out={pol,mag}, ref_out=new_ref.
- Input rate and strobes:
  - pix_valid must have at least one idle cycle between accepted pixels, because the downstream packer counts write_enable edges.
  - If pix_valid is high on two consecutive cycles, the second pixel is dropped, pix_cnt does not advance, and sync_err is set.
  - write_enable is never high on two consecutive cycles.
- Address/wrap:
  - address counts 0..FRAME_PIXELS-1. The first output pixel of every frame has address=0.
  - Pixels arriving in FLUSH or WAIT_VS are ignored.
- Reset mid-frame: the next frame is a prime frame again.

Test Plan:
- Prime: reset, frame of constant pix_data=100 → write_enable never pulses; 76800 BRAM writes of 400; frame_done pulses once; sync_err=0.
- Events: BRAM primed at 400, threshold=5, frame with pixel0=110, pixel1=90, pixel2=105 →
  - pixel0: pix_out=0x4A (ON, mag 10), ref_out=440
  - pixel1: pix_out=0x8A (OFF, mag 10), ref_out=360
  - pixel2: pix_out=0x00, ref_out=400
  - address 0,1,2, each on a 1-cycle write_enable 2 cycles after accept.
- Boundary and saturation: ref=400, threshold=5, pix_data=105 (diff exactly 20) → no event. pix_data=255 vs ref=0 → mag=63, pol=01.
- Short frame: vsync rising edge at pix_cnt=1000 → sync_err=1, no frame_done, next write_enable carries address=0.
- Back-to-back pix_valid: two consecutive strobes → one output only, sync_err=1, no consecutive write_enable cycles.
- Async reset at address 5000 → all outputs 0 immediately, no further ref_wr_en; the following frame behaves as prime.

Source files
------------

// File: rtl/dvs_event_gen.sv
// Dynamic-vision-sensor emulator: compares each camera pixel with a per-pixel
// reference held in external BRAM, emits an ON/OFF event code and writes back the new reference.
module dvs_event_gen #(
    parameter int H_RES        = 320,
    parameter int V_RES        = 240,
    parameter int FRAME_PIXELS = H_RES * V_RES,
    parameter int ADDR_W       = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    input  logic [7:0]        threshold,
    output logic [ADDR_W-1:0] ref_rd_addr,
    input  logic [9:0]        ref_rd_data,
    output logic              ref_wr_en,
    output logic [ADDR_W-1:0] ref_wr_addr,
    output logic [9:0]        ref_wr_data,
    output logic [7:0]        pix_out,
    output logic [9:0]        ref_out,
    output logic [ADDR_W-1:0] address,
    output logic              write_enable,
    output logic              frame_done,
    output logic              sync_err,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        FRAME   = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    state_t            state;
    logic              vsync_r;
    logic              strobe_r;
    logic [ADDR_W-1:0] pix_cnt;
    logic              prime;
    logic [7:0]        thr_r;
    logic [1:0]        flush_cnt;

    logic              s1_valid;
    logic [7:0]        s1_pix;
    logic [ADDR_W-1:0] s1_addr;

    logic              vs_rise;
    logic              strobe;
    logic              dup_strobe;
    logic              accept;

    // The camera strobe (href & pix_valid) has no backpressure: a pixel is
    // taken only in FRAME, never on the cycle after another strobe, and never
    // on a vsync rising edge; anything else is silently ignored.
    assign vs_rise     = vsync & ~vsync_r;
    assign strobe      = href & pix_valid;
    assign dup_strobe  = strobe & strobe_r;
    assign accept      = (state == FRAME) & strobe & ~strobe_r & ~vs_rise;
    assign ref_rd_addr = pix_cnt;
    assign fsm_state   = state;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            vsync_r  <= 1'b0;
            strobe_r <= 1'b0;
        end else begin
            vsync_r  <= vsync;
            strobe_r <= strobe;
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state      <= WAIT_VS;
            pix_cnt    <= '0;
            prime      <= 1'b1;
            thr_r      <= 8'd0;
            flush_cnt  <= 2'd0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                WAIT_VS: begin
                    if (vs_rise) begin
                        thr_r   <= threshold;
                        pix_cnt <= '0;
                        state   <= FRAME;
                    end
                end
                FRAME: begin
                    if (vs_rise) begin
                        // Short frame restarts in place; in-flight pixels still drain.
                        thr_r   <= threshold;
                        pix_cnt <= '0;
                        if (pix_cnt != '0) begin
                            sync_err <= 1'b1;
                        end
                    end else if (accept) begin
                        if (pix_cnt == LAST_ADDR) begin
                            pix_cnt   <= '0;
                            flush_cnt <= 2'd0;
                            state     <= FLUSH;
                        end else begin
                            pix_cnt <= pix_cnt + ADDR_W'(1);
                        end
                    end
                    if (dup_strobe) begin
                        sync_err <= 1'b1;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 2'd1;
                    if (flush_cnt == 2'd1) begin
                        frame_done <= 1'b1;
                        prime      <= 1'b0;
                        state      <= WAIT_VS;
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_pix   <= 8'd0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_pix  <= pix_data;
                s1_addr <= pix_cnt;
            end
        end
    end

    logic [9:0]  cur;
    logic [10:0] diff;
    logic [10:0] thr_ext;
    logic [10:0] abs_diff;
    logic [8:0]  mag_full;
    logic        is_on;
    logic        is_off;
    logic [1:0]  pol;
    logic [5:0]  mag;
    logic [9:0]  new_ref;

    always_comb begin
        cur      = {s1_pix, 2'b00};
        diff     = {1'b0, cur} - {1'b0, ref_rd_data};
        thr_ext  = {1'b0, thr_r, 2'b00};
        abs_diff = diff[10] ? (~diff + 11'd1) : diff;
        mag_full = abs_diff[10:2];
        is_on    = $signed(diff) > $signed(thr_ext);
        is_off   = $signed(diff) < -$signed(thr_ext);
        pol      = 2'b00;
        if (!prime) begin
            if (is_on) begin
                pol = 2'b01;
            end else if (is_off) begin
                pol = 2'b10;
            end
        end
        mag = 6'd0;
        if (pol != 2'b00) begin
            mag = (mag_full > 9'd63) ? 6'd63 : mag_full[5:0];
        end
        new_ref = (prime || pol != 2'b00) ? cur : ref_rd_data;
    end

    // During the prime frame the BRAM is seeded but the packer sees nothing.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            ref_wr_en    <= 1'b0;
            ref_wr_addr  <= '0;
            ref_wr_data  <= 10'd0;
            pix_out      <= 8'd0;
            ref_out      <= 10'd0;
            address      <= '0;
            write_enable <= 1'b0;
        end else begin
            ref_wr_en    <= s1_valid;
            write_enable <= s1_valid & ~prime;
            if (s1_valid) begin
                ref_wr_addr <= s1_addr;
                ref_wr_data <= new_ref;
                address     <= s1_addr;
                pix_out     <= {pol, mag};
                ref_out     <= new_ref;
            end
        end
    end

endmodule

// File: tb/tb_dvs_event_gen.sv
// Directed bench for dvs_event_gen on a reduced 16x4 frame, with a BRAM model
// and expected event codes computed by hand.
module tb_dvs_event_gen;

    localparam int H_RES = 16;
    localparam int V_RES = 4;
    localparam int FP    = H_RES * V_RES;
    localparam int AW    = 17;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic          pix_valid = 1'b0;
    logic [7:0]    pix_data = 8'd0;
    logic [7:0]    threshold = 8'd0;
    logic [AW-1:0] ref_rd_addr;
    logic [9:0]    ref_rd_data;
    logic          ref_wr_en;
    logic [AW-1:0] ref_wr_addr;
    logic [9:0]    ref_wr_data;
    logic [7:0]    pix_out;
    logic [9:0]    ref_out;
    logic [AW-1:0] address;
    logic          write_enable;
    logic          frame_done;
    logic          sync_err;
    logic [1:0]    fsm_state;

    dvs_event_gen #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(AW)) dut (
        .pclk(pclk), .reset(reset), .vsync(vsync), .href(href),
        .pix_valid(pix_valid), .pix_data(pix_data), .threshold(threshold),
        .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
        .ref_wr_en(ref_wr_en), .ref_wr_addr(ref_wr_addr), .ref_wr_data(ref_wr_data),
        .pix_out(pix_out), .ref_out(ref_out), .address(address),
        .write_enable(write_enable), .frame_done(frame_done),
        .sync_err(sync_err), .fsm_state(fsm_state)
    );

    // clock / cycle counter
    always #5 pclk = ~pclk;
    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // BRAM model: registered read, write port, and a bench-side poke
    logic [9:0] mem [0:FP-1];
    logic       poke_en = 1'b0;
    logic [5:0] poke_addr = 6'd0;
    logic [9:0] poke_val = 10'd0;
    always @(posedge pclk) begin
        ref_rd_data <= mem[ref_rd_addr[5:0]];
        if (ref_wr_en) mem[ref_wr_addr[5:0]] <= ref_wr_data;
        if (poke_en) mem[poke_addr] <= poke_val;
    end

    // output monitor
    int          we_cnt = 0, wr_cnt = 0, fd_cnt = 0, consec = 0;
    int          last_wr_cyc = 0, fd_cyc = 0;
    logic        we_prev = 1'b0;
    logic [34:0] cap [0:511];
    int          cap_cyc [0:511];
    always @(negedge pclk) begin
        if (write_enable && we_cnt < 512) begin
            cap[we_cnt]     = {address, pix_out, ref_out};
            cap_cyc[we_cnt] = cyc;
        end
        if (write_enable) we_cnt++;
        if (write_enable && we_prev) consec++;
        we_prev = write_enable;
        if (ref_wr_en) begin
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    // scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [34:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    int acc_cyc = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] p);
        @(posedge pclk); #1;
        href = 1'b1; pix_valid = 1'b1; pix_data = p; acc_cyc = cyc;
        @(posedge pclk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic send_dup(input logic [7:0] p1, input logic [7:0] p2);
        @(posedge pclk); #1;
        href = 1'b1; pix_valid = 1'b1; pix_data = p1;
        @(posedge pclk); #1;
        pix_data = p2;
        @(posedge pclk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] thr);
        @(posedge pclk); #1;
        threshold = thr; vsync = 1'b1;
        tick(2);
        vsync = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] val);
        for (int i = 0; i < FP; i++) send_pix(val);
        tick(8);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, write_enable, 1'b0);
        check({tag, "_wr"}, ref_wr_en, 1'b0);
        check({tag, "_out"}, {pix_out, ref_out, address}, '0);
        check({tag, "_wraddr"}, {ref_wr_addr, ref_wr_data, ref_rd_addr}, '0);
        check({tag, "_fd"}, {frame_done, sync_err, fsm_state}, '0);
    endtask

    int b_we, b_wr, b_fd, bad, acc0;
    logic [7:0] ev_pix [0:5];

    initial begin
        // reset state
        #2 reset = 1'b0;
        #1 check_zero("rst_async");
        tick(3);
        check_zero("rst_hold");
        reset = 1'b1;

        // prime frame
        b_we = we_cnt; b_wr = wr_cnt; b_fd = fd_cnt;
        start_frame(8'd5);
        run_frame(8'd100);
        check("prime_we", we_cnt - b_we, 0);
        check("prime_wr", wr_cnt - b_wr, FP);
        check("prime_fd", fd_cnt - b_fd, 1);
        check("prime_fd_timing", fd_cyc - last_wr_cyc, 1);
        check("prime_sync_err", sync_err, 1'b0);
        check("prime_state", fsm_state, 2'd0);
        bad = 0;
        for (int i = 0; i < FP; i++) if (mem[i] !== 10'd400) bad++;
        check("prime_bram", bad, 0);

        // events frame: ref[3] forced to 0 for saturation
        poke_addr = 6'd3; poke_val = 10'd0; poke_en = 1'b1;
        tick(1);
        poke_en = 1'b0;
        ev_pix[0] = 8'd110; ev_pix[1] = 8'd90;  ev_pix[2] = 8'd105;
        ev_pix[3] = 8'd255; ev_pix[4] = 8'd0;   ev_pix[5] = 8'd101;
        exp_q.push_back({17'd0, 8'h4A, 10'd440});
        exp_q.push_back({17'd1, 8'h8A, 10'd360});
        exp_q.push_back({17'd2, 8'h00, 10'd400});
        exp_q.push_back({17'd3, 8'h7F, 10'd1020});
        exp_q.push_back({17'd4, 8'hBF, 10'd0});
        exp_q.push_back({17'd5, 8'h00, 10'd400});
        for (int i = 6; i < FP; i++) exp_q.push_back({17'(i), 8'h00, 10'd400});
        b_we = we_cnt; b_fd = fd_cnt;
        start_frame(8'd5);
        for (int i = 0; i < FP; i++) begin
            send_pix(i < 6 ? ev_pix[i] : 8'd100);
            if (i == 0) acc0 = acc_cyc;
        end
        tick(8);
        check("ev_count", we_cnt - b_we, FP);
        check("ev_latency", cap_cyc[b_we] - acc0, 2);
        for (int i = 0; i < FP; i++) check($sformatf("ev_px%0d", i), cap[b_we + i], exp_q.pop_front());
        check("ev_consec", consec, 0);
        check("ev_fd", fd_cnt - b_fd, 1);
        check("ev_sync_err", sync_err, 1'b0);

        // short frame with a new threshold on restart
        start_frame(8'd5);
        for (int i = 0; i < 10; i++) send_pix(8'd100);
        tick(3);
        check("short_pre_err", sync_err, 1'b0);
        b_fd = fd_cnt;
        start_frame(8'd20);
        tick(3);
        check("short_sync_err", sync_err, 1'b1);
        b_we = we_cnt;
        send_pix(8'd110);
        tick(4);
        check("short_count", we_cnt - b_we, 1);
        check("short_first", cap[b_we], {17'd0, 8'h00, 10'd400});
        check("short_no_fd", fd_cnt - b_fd, 0);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        check("short_err_clear", sync_err, 1'b0);

        // back-to-back strobes after a fresh prime frame
        start_frame(8'd5);
        run_frame(8'd100);
        b_we = we_cnt;
        start_frame(8'd5);
        send_dup(8'd110, 8'd90);
        send_pix(8'd90);
        tick(4);
        check("dup_count", we_cnt - b_we, 2);
        check("dup_px0", cap[b_we], {17'd0, 8'h4A, 10'd440});
        check("dup_px1", cap[b_we + 1], {17'd1, 8'h8A, 10'd360});
        check("dup_sync_err", sync_err, 1'b1);
        check("dup_consec", consec, 0);

        // async reset with a pixel in flight
        for (int i = 2; i < 20; i++) send_pix(8'd100);
        tick(3);
        check("mid_addr", address, 17'd19);
        @(posedge pclk); #1;
        pix_valid = 1'b1; pix_data = 8'd100;
        @(posedge pclk); #2;
        reset = 1'b0;
        #1 check_zero("mid_rst");
        pix_valid = 1'b0;
        b_wr = wr_cnt;
        tick(4);
        check("mid_no_write", wr_cnt - b_wr, 0);
        reset = 1'b1;

        // following frame must be a prime frame
        b_we = we_cnt; b_wr = wr_cnt; b_fd = fd_cnt;
        start_frame(8'd5);
        run_frame(8'd120);
        check("reprime_we", we_cnt - b_we, 0);
        check("reprime_wr", wr_cnt - b_wr, FP);
        check("reprime_fd", fd_cnt - b_fd, 1);
        check("reprime_bram0", mem[0], 10'd480);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
